ssd_scan_ctrl: RTL and testbench
================================

SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, 262144, board_clk cycles per digit slot; legal values are 4 to 2^24.
REQ-002 Parameter BLANK_CYC, 1024, cycles at the start of each slot with all anodes off; legal values are 1 to SCAN_DIV-2.
REQ-003 board_clk  input  1  system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 digit_data  input  32  eight hex nibbles; nibble i is [4i+3:4i] and drives digit i.
REQ-006 digit_en  input  8  per-digit enable mask; 1 means the digit is lit.
REQ-007 upd_req  input  1  request to load digit_data/digit_en into the shadow registers; held until upd_ack.
REQ-008 upd_ack  output  1  one-cycle pulse confirming the shadow load.
REQ-009 an  output  8  anodes, active-low; an[i] selects digit i.
REQ-010 seg  output  7  cathodes {CA,CB,CC,CD,CE,CF,CG}, active-low.
REQ-011 dp  output  1  decimal-point cathode, active-low.
REQ-012 frame_done  output  1  one-cycle pulse when digit 7's slot ends.

Function
REQ-013 Internal slot counter cnt SHALL count 0..SCAN_DIV-1, then wrap to 0; its width SHALL be the minimum needed to hold SCAN_DIV-1.
REQ-014 Digit index d (3 bits) SHALL increment on each cnt wrap, going 0..7 and wrapping 7->0.
REQ-015 The slot state machine SHALL have two states: BLANK while cnt < BLANK_CYC, and SHOW while cnt >= BLANK_CYC.
REQ-016 In SHOW, an[d] SHALL be 0 only if en_sh[d]=1, and all other anode bits SHALL be 1; in BLANK, an SHALL be 8'hFF.
REQ-017 seg SHALL be the standard hex decode of data_sh nibble d, active-low:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0000100, A=0001000, B=1100000, C=0110001, D=1000010, E=0110000, F=0111000
REQ-018 In BLANK, or when the current digit is disabled, seg SHALL be 7'h7F.
REQ-019 an, seg, dp, upd_ack and frame_done SHALL be registered, with exactly one cycle of latency from the cnt/d values that produce them.
REQ-020 A disabled digit SHALL still consume its full slot, so the frame period is constant at 8*SCAN_DIV cycles.
REQ-021 Shadow capture: if upd_req=1 in the cycle where cnt=SCAN_DIV-1 and d=7, data_sh/en_sh SHALL load digit_data/digit_en on that edge.
REQ-022 upd_ack SHALL pulse in the following cycle, coincident with frame_done.
REQ-023 upd_req asserted mid-frame SHALL be ignored until the next frame boundary; no partial-frame updates.
REQ-024 If upd_req is still high in the cycle upd_ack is high, no second capture SHALL occur until the next frame boundary.
REQ-025 Deasserting upd_req before upd_ack is a requester protocol violation; the block SHALL capture only if upd_req=1 at the boundary cycle.

Reset
REQ-026 On reset assertion, without waiting for a clock edge:
- an SHALL go to 8'hFF, seg to 7'h7F, dp to 1;
- upd_ack and frame_done SHALL go to 0;
- cnt and d SHALL go to 0;
- data_sh SHALL go to 32'h0 and en_sh to 8'h00.
REQ-027 Reset asserted mid-frame SHALL abort the frame and drop any pending request; no upd_ack SHALL be issued for it.
REQ-028 After reset release, the first frame boundary SHALL occur 8*SCAN_DIV cycles later.

Configuration
REQ-029 Macro SSD_SCAN_DP_EN is the one compile-time option.
REQ-030 With SSD_SCAN_DP_EN defined:
- an additional input dp_in (8 bits) SHALL exist;
- dp_in SHALL be captured into dp_sh together with digit_data;
- in SHOW, for an enabled digit, dp SHALL equal ~dp_sh[d], and SHALL be 1 otherwise.
REQ-031 Without SSD_SCAN_DP_EN, the dp_in port SHALL be absent and dp SHALL be constant 1.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-032 Reset release, upd_req held at 0 -> an=FF and seg=7F throughout; frame_done pulses every 64 cycles.
REQ-033 upd_req=1, digit_data=32'h76543210, digit_en=8'hFF ->
- upd_ack and frame_done pulse together 64 cycles after release;
- in the next frame, each digit i has an[i]=0 for 6 of its 8 cycles with seg=hex(i);
- digit 0 shows 0000001 and digit 7 shows 0001111.
REQ-034 digit_en=8'h05 -> only an[0] and an[2] ever go low; the frame remains 64 cycles long.
REQ-035 upd_req rises at cycle 10 of a frame with new data -> display unchanged until the boundary; upd_ack at cycle 64; new data shown from the next frame.
REQ-036 Reset asserted at cycle 30 with upd_req=1 -> outputs go to reset values immediately; no upd_ack; if upd_req is held, capture occurs 64 cycles after release.
REQ-037 SSD_SCAN_DP_EN defined, dp_in=8'h80, all digits enabled -> dp=0 only during digit 7's SHOW cycles.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: eight-digit multiplexed seven-segment scanner with blanking and frame-boundary shadow update.
// Option macro SSD_SCAN_DP_EN adds the dp_in port and per-digit decimal points (dp is constant 1 otherwise).
module ssd_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 262144,
  parameter int unsigned BLANK_CYC = 1024
) (
  input  logic        board_clk,
  input  logic        reset,
  input  logic [31:0] digit_data,
  input  logic [7:0]  digit_en,
`ifdef SSD_SCAN_DP_EN
  input  logic [7:0]  dp_in,
`endif
  input  logic        upd_req,
  output logic        upd_ack,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       d_q, d_d;
  logic [31:0]      data_sh_q;
  logic [7:0]       en_sh_q;
`ifdef SSD_SCAN_DP_EN
  logic [7:0]       dp_sh_q;
`endif
  logic             last_cyc, frame_end, lit;
  logic [3:0]       nib;
  logic [7:0]       an_d;
  logic [6:0]       seg_d;
  logic             dp_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    last_cyc  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end = last_cyc && (d_q == 3'd7);
    cnt_d     = last_cyc ? '0 : cnt_q + CNT_W'(1);
    d_d       = last_cyc ? d_q + 3'd1 : d_q;
    // state_q always describes cnt_q, so outputs below lag cnt/d by exactly one register
    state_d   = (cnt_d < CNT_W'(BLANK_CYC)) ? BLANK : SHOW;
    nib       = data_sh_q[{d_q, 2'b00} +: 4];
    lit       = (state_q == SHOW) && en_sh_q[d_q];
    an_d      = 8'hFF;
    if (lit) an_d[d_q] = 1'b0;
    seg_d     = lit ? hex7(nib) : 7'h7F;
`ifdef SSD_SCAN_DP_EN
    dp_d      = lit ? ~dp_sh_q[d_q] : 1'b1;
`else
    dp_d      = 1'b1;
`endif
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      d_q        <= '0;
      state_q    <= BLANK;
      data_sh_q  <= '0;
      en_sh_q    <= '0;
`ifdef SSD_SCAN_DP_EN
      dp_sh_q    <= '0;
`endif
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      d_q        <= d_d;
      state_q    <= state_d;
      an         <= an_d;
      seg        <= seg_d;
      dp         <= dp_d;
      frame_done <= frame_end;
      upd_ack    <= frame_end && upd_req;
      // Shadow only moves on the frame boundary, so a frame never mixes old and new data
      if (frame_end && upd_req) begin
        data_sh_q <= digit_data;
        en_sh_q   <= digit_en;
`ifdef SSD_SCAN_DP_EN
        dp_sh_q   <= dp_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl at SCAN_DIV=8, BLANK_CYC=2 (64-cycle frames).
module tb_ssd_scan_ctrl;
  localparam int SD = 8;
  localparam int BC = 2;

  logic        board_clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] digit_data = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp_in = 8'h80;
  logic        upd_req = 1'b0;
  logic        upd_ack, dp, frame_done;
  logic [7:0]  an;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_bad = 0;
  int k = 0;

  logic [6:0] hex_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  ssd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .board_clk(board_clk), .reset(reset), .digit_data(digit_data), .digit_en(digit_en),
`ifdef SSD_SCAN_DP_EN
    .dp_in(dp_in),
`endif
    .upd_req(upd_req), .upd_ack(upd_ack), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 board_clk = ~board_clk;

  task automatic tick;
    @(posedge board_clk);
    #1;
    k++;
  endtask

  // Outputs seen after edge kk reflect the counter state before that edge.
  function automatic logic lit_at(int kk, logic [7:0] en);
    int p;
    if (kk < 1) return 1'b0;
    p = (kk - 1) % 64;
    return ((p % SD) >= BC) && en[p / SD];
  endfunction

  function automatic logic [7:0] exp_an(int kk, logic [7:0] en);
    logic [7:0] a;
    a = 8'hFF;
    if (lit_at(kk, en)) a[((kk - 1) % 64) / SD] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg(int kk, logic [31:0] dat, logic [7:0] en);
    int dd;
    dd = ((kk - 1) % 64) / SD;
    return lit_at(kk, en) ? hex_tab[dat[4*dd +: 4]] : 7'h7F;
  endfunction

  function automatic logic exp_dp(int kk, logic [7:0] en, logic [7:0] dsh);
`ifdef SSD_SCAN_DP_EN
    return lit_at(kk, en) ? ~dsh[((kk - 1) % 64) / SD] : 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic release_reset;
    repeat (3) begin
      @(posedge board_clk);
      #1;
      n_cmp++;
      if (upd_ack !== 1'b0) begin n_bad++; $display("FAIL ack_in_reset got %b want 0", upd_ack); end
    end
    @(negedge board_clk);
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    n_cmp += 5;
    if (an !== 8'hFF)      begin n_bad++; $display("FAIL rst_an got %h want ff", an); end
    if (seg !== 7'h7F)     begin n_bad++; $display("FAIL rst_seg got %h want 7f", seg); end
    if (dp !== 1'b1)       begin n_bad++; $display("FAIL rst_dp got %b want 1", dp); end
    if (upd_ack !== 1'b0)  begin n_bad++; $display("FAIL rst_ack got %b want 0", upd_ack); end
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_fd got %b want 0", frame_done); end
    release_reset();
  endtask

  task automatic test_idle;
    repeat (128) begin
      tick();
      n_cmp += 4;
      if (an !== 8'hFF)  begin n_bad++; $display("FAIL idle_an k=%0d got %h want ff", k, an); end
      if (seg !== 7'h7F) begin n_bad++; $display("FAIL idle_seg k=%0d got %h want 7f", k, seg); end
      if (frame_done !== (k % 64 == 0)) begin n_bad++; $display("FAIL idle_fd k=%0d got %b want %b", k, frame_done, k % 64 == 0); end
      if (upd_ack !== 1'b0) begin n_bad++; $display("FAIL idle_ack k=%0d got %b want 0", k, upd_ack); end
    end
  endtask

  task automatic test_full_update;
    int lows [8];
    logic [31:0] sd;
    logic [7:0]  se, sp;
    foreach (lows[i]) lows[i] = 0;
    reset = 1'b1;
    upd_req = 1'b1; digit_data = 32'h76543210; digit_en = 8'hFF;
    release_reset();
    repeat (128) begin
      tick();
      sd = (k > 64) ? 32'h76543210 : 32'h0;
      se = (k > 64) ? 8'hFF : 8'h00;
      sp = (k > 64) ? 8'h80 : 8'h00;
      n_cmp += 5;
      if (an !== exp_an(k, se))       begin n_bad++; $display("FAIL full_an k=%0d got %h want %h", k, an, exp_an(k, se)); end
      if (seg !== exp_seg(k, sd, se)) begin n_bad++; $display("FAIL full_seg k=%0d got %b want %b", k, seg, exp_seg(k, sd, se)); end
      if (dp !== exp_dp(k, se, sp))   begin n_bad++; $display("FAIL full_dp k=%0d got %b want %b", k, dp, exp_dp(k, se, sp)); end
      if (upd_ack !== (k == 64))      begin n_bad++; $display("FAIL full_ack k=%0d got %b want %b", k, upd_ack, k == 64); end
      if (frame_done !== (k % 64 == 0)) begin n_bad++; $display("FAIL full_fd k=%0d got %b want %b", k, frame_done, k % 64 == 0); end
      if (k == 64) upd_req = 1'b0;
      if (k > 64) for (int i = 0; i < 8; i++) if (an[i] === 1'b0) lows[i]++;
      if (k == 67) begin
        n_cmp++;
        if (seg !== 7'b0000001) begin n_bad++; $display("FAIL full_dig0 got %b want 0000001", seg); end
      end
      if (k == 123) begin
        n_cmp++;
        if (seg !== 7'b0001111) begin n_bad++; $display("FAIL full_dig7 got %b want 0001111", seg); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (lows[i] != 6) begin n_bad++; $display("FAIL full_lowcnt digit %0d got %0d want 6", i, lows[i]); end
    end
  endtask

  task automatic test_mid_frame_and_mask;
    logic [31:0] sd;
    logic [7:0]  se;
    repeat (128) begin
      tick();
      if (k == 138) begin
        upd_req = 1'b1; digit_data = 32'hFEDCBA98; digit_en = 8'h05;
      end
      sd = (k > 192) ? 32'hFEDCBA98 : 32'h76543210;
      se = (k > 192) ? 8'h05 : 8'hFF;
      n_cmp += 4;
      if (an !== exp_an(k, se))       begin n_bad++; $display("FAIL mid_an k=%0d got %h want %h", k, an, exp_an(k, se)); end
      if (seg !== exp_seg(k, sd, se)) begin n_bad++; $display("FAIL mid_seg k=%0d got %b want %b", k, seg, exp_seg(k, sd, se)); end
      if (upd_ack !== (k == 192))     begin n_bad++; $display("FAIL mid_ack k=%0d got %b want %b", k, upd_ack, k == 192); end
      if (frame_done !== (k % 64 == 0)) begin n_bad++; $display("FAIL mid_fd k=%0d got %b want %b", k, frame_done, k % 64 == 0); end
      if (k > 192) begin
        n_cmp++;
        if ((~an & 8'hFA) !== 8'h00) begin n_bad++; $display("FAIL mask_an k=%0d got %h want only bits 0,2 low", k, an); end
      end
      // Request stays high through the ack cycle with changed data; it must not be captured
      if (k == 192) digit_data = 32'h11111111;
      if (k == 193) upd_req = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] sd;
    logic [7:0]  se;
    upd_req = 1'b1; digit_data = 32'h0000000A; digit_en = 8'h01;
    repeat (30) tick();
    #2 reset = 1'b1;
    #1;
    n_cmp += 5;
    if (an !== 8'hFF)      begin n_bad++; $display("FAIL mrst_an got %h want ff", an); end
    if (seg !== 7'h7F)     begin n_bad++; $display("FAIL mrst_seg got %h want 7f", seg); end
    if (dp !== 1'b1)       begin n_bad++; $display("FAIL mrst_dp got %b want 1", dp); end
    if (upd_ack !== 1'b0)  begin n_bad++; $display("FAIL mrst_ack got %b want 0", upd_ack); end
    if (frame_done !== 1'b0) begin n_bad++; $display("FAIL mrst_fd got %b want 0", frame_done); end
    release_reset();
    repeat (128) begin
      tick();
      sd = (k > 64) ? 32'h0000000A : 32'h0;
      se = (k > 64) ? 8'h01 : 8'h00;
      n_cmp += 4;
      if (an !== exp_an(k, se))       begin n_bad++; $display("FAIL post_an k=%0d got %h want %h", k, an, exp_an(k, se)); end
      if (seg !== exp_seg(k, sd, se)) begin n_bad++; $display("FAIL post_seg k=%0d got %b want %b", k, seg, exp_seg(k, sd, se)); end
      if (upd_ack !== (k == 64))      begin n_bad++; $display("FAIL post_ack k=%0d got %b want %b", k, upd_ack, k == 64); end
      if (frame_done !== (k % 64 == 0)) begin n_bad++; $display("FAIL post_fd k=%0d got %b want %b", k, frame_done, k % 64 == 0); end
      if (k == 64) upd_req = 1'b0;
      if (k == 67) begin
        n_cmp += 2;
        if (seg !== 7'b0001000) begin n_bad++; $display("FAIL post_digA got %b want 0001000", seg); end
        if (an !== 8'hFE)       begin n_bad++; $display("FAIL post_an0 got %h want fe", an); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_full_update();
    test_mid_frame_and_mask();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
